// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, reading atan(2^-i) from an
// external combinational table addressed by which_angle. Rotation mode drives z to 0;
// vectoring mode (built only when CORDIC_VECTORING_EN is defined) drives y to 0.
// Results are not gain-compensated (K ~= 1.6468).
// A start on the edge that ends DONE is accepted, so back-to-back operations run at
// one per ITERATIONS+1 cycles.
module cordic_iter_engine #(
  parameter int unsigned FIXED_WIDTH = 16,
  parameter int unsigned ITERATIONS  = 9,
  localparam int unsigned IdxW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mode,
  input  logic signed [FIXED_WIDTH-1:0] x_in,
  input  logic signed [FIXED_WIDTH-1:0] y_in,
  input  logic signed [FIXED_WIDTH-1:0] z_in,
  output logic        [IdxW-1:0]        which_angle,
  input  logic signed [FIXED_WIDTH-1:0] angle_in,
  output logic signed [FIXED_WIDTH-1:0] x_out,
  output logic signed [FIXED_WIDTH-1:0] y_out,
  output logic signed [FIXED_WIDTH-1:0] z_out,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t                         state_q;
  logic        [IdxW-1:0]         idx_q;
  logic signed [FIXED_WIDTH-1:0]  x_q, y_q, z_q;
  logic signed [FIXED_WIDTH-1:0]  x_shr, y_shr;
  logic signed [FIXED_WIDTH-1:0]  x_nxt, y_nxt, z_nxt;
  logic                           d_pos;
  logic                           last_iter;

`ifdef CORDIC_VECTORING_EN
  logic mode_q;
`else
  // mode is deliberately ignored in rotation-only builds
  logic unused_mode;
  assign unused_mode = mode;
`endif

  // idx is cleared outside RUN, so it doubles as the table index
  assign which_angle = idx_q;
  assign last_iter   = (idx_q == IdxW'(ITERATIONS - 1));

  // Direction choice and one micro-rotation with wrapping arithmetic
  always_comb begin
    x_shr = x_q >>> idx_q;
    y_shr = y_q >>> idx_q;
`ifdef CORDIC_VECTORING_EN
    d_pos = mode_q ? y_q[FIXED_WIDTH-1] : ~z_q[FIXED_WIDTH-1];
`else
    d_pos = ~z_q[FIXED_WIDTH-1];
`endif
    if (d_pos) begin
      x_nxt = x_q - y_shr;
      y_nxt = y_q + x_shr;
      z_nxt = z_q - angle_in;
    end else begin
      x_nxt = x_q + y_shr;
      y_nxt = y_q - x_shr;
      z_nxt = z_q + angle_in;
    end
  end

  // Control FSM, working registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
`ifdef CORDIC_VECTORING_EN
      mode_q  <= 1'b0;
`endif
      x_out   <= '0;
      y_out   <= '0;
      z_out   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            x_q     <= x_in;
            y_q     <= y_in;
            z_q     <= z_in;
`ifdef CORDIC_VECTORING_EN
            mode_q  <= mode;
`endif
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          z_q <= z_nxt;
          if (last_iter) begin
            x_out   <= x_nxt;
            y_out   <= y_nxt;
            z_out   <= z_nxt;
            idx_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine: the driver pushes expected results computed
// by a plain-integer CORDIC model; a monitor pops and compares on every done pulse.
// Honours CORDIC_VECTORING_EN the same way the design does.
module tb_cordic_iter_engine;

  localparam int W = 16;
  localparam int N = 9;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } res_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                mode;
  logic signed [W-1:0] x_in, y_in, z_in;
  logic        [3:0]   which_angle;
  logic signed [W-1:0] angle_in;
  logic signed [W-1:0] x_out, y_out, z_out;
  logic                busy;
  logic                done;

  int   atan_tab [N] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64};
  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_count = 0;

  cordic_iter_engine #(.FIXED_WIDTH(W), .ITERATIONS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .x_in        (x_in),
    .y_in        (y_in),
    .z_in        (z_in),
    .which_angle (which_angle),
    .angle_in    (angle_in),
    .x_out       (x_out),
    .y_out       (y_out),
    .z_out       (z_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Combinational arctangent table
  assign angle_in = (which_angle < 4'(N)) ? W'(atan_tab[which_angle]) : '0;

  function automatic int wrap16(int v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  // Reference: the CORDIC recurrence in plain integers, wrapped to 16 bits each step
  function automatic res_t model(int x0, int y0, int z0, bit m);
    int x, y, z, xn, yn, zn;
    bit dpos;
    res_t r;
`ifndef CORDIC_VECTORING_EN
    m = 1'b0;
`endif
    x = x0; y = y0; z = z0;
    for (int i = 0; i < N; i++) begin
      dpos = m ? (y < 0) : (z >= 0);
      if (dpos) begin
        xn = x - (y >>> i); yn = y + (x >>> i); zn = z - atan_tab[i];
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); zn = z + atan_tab[i];
      end
      x = wrap16(xn); y = wrap16(yn); z = wrap16(zn);
    end
    r.x = W'(x); r.y = W'(y); r.z = W'(z);
    return r;
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_near(string name, int act, int req, int tol);
    int diff;
    diff = act - req;
    if (diff < 0) diff = -diff;
    n_cmp++;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d +/- %0d", name, act, req, tol);
    end
  endtask

  // Monitor: scoreboard compare on done, single-cycle done, result stability otherwise
  logic        prev_done = 1'b0;
  logic [47:0] prev_res  = '0;
  always @(negedge clk) begin
    res_t e;
    if (!rst) begin
      if (done) begin
        done_count++;
        check("done_with_busy_low", int'(busy), 0);
        check("done_single_cycle", int'(prev_done), 0);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: got done, required no pending operation");
        end else begin
          e = exp_q.pop_front();
          check("x_out", int'(x_out), int'($signed(e.x)));
          check("y_out", int'(y_out), int'($signed(e.y)));
          check("z_out", int'(z_out), int'($signed(e.z)));
        end
      end else begin
        check("results_stable", int'({x_out, y_out, z_out} == prev_res), 1);
      end
      check("which_angle_range", int'(which_angle < 4'(N)), 1);
    end
    prev_done = done;
    prev_res  = {x_out, y_out, z_out};
  end

  // Issue one start pulse (called just after a posedge) and record the expectation
  task automatic issue(int x, int y, int z, bit m);
    x_in = W'(x); y_in = W'(y); z_in = W'(z); mode = m;
    start = 1'b1;
    exp_q.push_back(model(wrap16(x), wrap16(y), wrap16(z), m));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done, counting busy cycles and checking the table index sequence
  task automatic wait_done(output int busy_cycles);
    bit seen;
    seen = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) begin
        check("which_angle_seq", int'(which_angle), busy_cycles);
        busy_cycles++;
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done within 20 cycles, required done");
    end
  endtask

  task automatic directed(int x, int y, int z, bit m);
    int bc;
    issue(x, y, z, m);
    wait_done(bc);
    check("busy_cycles", bc, N);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, base, w;
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    #12;
    check("rst_x_out", int'(x_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_which_angle", int'(which_angle), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Rotation by pi/4 with prescaled unit vector
    directed(9949, 0, 12868, 1'b0);
    check_near("rot45_x", int'(x_out), 11585, 160);
    check_near("rot45_y", int'(y_out), 11585, 160);
    check_near("rot45_z", int'(z_out), 0, 64);
    @(posedge clk); #1;

    directed(9949, 0, 0, 1'b0);
    check_near("rot0_x", int'(x_out), 16384, 160);
    check_near("rot0_y", int'(y_out), 0, 160);
    @(posedge clk); #1;

    directed(9949, 0, -12868, 1'b0);
    check_near("rotneg_x", int'(x_out), 11585, 160);
    check_near("rotneg_y", int'(y_out), -11585, 160);
    @(posedge clk); #1;

    directed(8192, 8192, 0, 1'b1);
`ifdef CORDIC_VECTORING_EN
    check_near("vec_z", int'(z_out), 12868, 64);
    check_near("vec_x", int'(x_out), 19079, 160);
    check_near("vec_y", int'(y_out), 0, 64);
`else
    check_near("vec_as_rot_z", int'(z_out), 0, 64);
    check_near("vec_as_rot_x", int'(x_out), 13491, 160);
`endif
    @(posedge clk); #1;

    // start held for 30 cycles with operands changing every cycle
    base = done_count;
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      x_in = W'($urandom_range(0, 16000) - 8000);
      y_in = W'($urandom_range(0, 16000) - 8000);
      z_in = W'($urandom_range(0, 25000) - 12500);
      mode = 1'($urandom_range(0, 1));
      if (k % 10 == 0)
        exp_q.push_back(model(int'(x_in), int'(y_in), int'(z_in), mode));
      @(posedge clk); #1;
    end
    start = 1'b0;
    w = 0;
    while (done_count < base + 3 && w < 40) begin
      @(negedge clk); w++;
    end
    repeat (15) @(negedge clk);
    check("held_start_done_pulses", done_count - base, 3);
    @(posedge clk); #1;

    // Reset in the middle of iteration 4: aborts with no done pulse
    issue(9949, 0, 12868, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    base = done_count;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("midrst_x_out", int'(x_out), 0);
    check("midrst_y_out", int'(y_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_which_angle", int'(which_angle), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_count - base, 0);
    @(posedge clk); #1;
    directed(9949, 0, 12868, 1'b0);
    check_near("post_rst_x", int'(x_out), 11585, 160);
    @(posedge clk); #1;

    // Randomised operations
    for (int r = 0; r < 20; r++) begin
      directed(int'($urandom_range(0, 24000)) - 12000, int'($urandom_range(0, 24000)) - 12000,
               int'($urandom_range(0, 40000)) - 20000, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
